regfile_2r1w_sb: RTL and testbench

//  Parametrised register file: two read ports, one write port, with per-register pending
//  (scoreboard) bits. Successor to the 8x16 single-read-port file in the datapath.

---
 rtl/regfile_pkg.sv | 26 ++
 rtl/regfile_read_port.sv | 112 +++++++++++
 rtl/regfile_2r1w_sb.sv | 156 +++++++++++++++
 tb/tb_regfile_2r1w_sb.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_pkg
//  Purpose  : Shared constants and helpers for the 2R1W scoreboarded
//             register file (default geometry and index-width helper).
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package regfile_pkg;

    // Ceiling log2, minimum 1 so a 2-entry file still has a 1-bit index.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int RF_WIDTH = 16;
    localparam int RF_NREGS = 8;
    localparam int RF_AW    = clog2(RF_NREGS);

endpackage
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_read_port
//  Purpose  : One read port of the register file: index range check,
//             NREGS:1 data/pending mux, write-bypass compare and an optional
//             output register.
//  Ports    : clk, reset         clock / async active-high reset
//             regs, pend         storage array and pending vector
//             wr_fwd, wr_addr,   in-range write this cycle (for bypass)
//             wr_data
//             rsv_fwd, rsv_addr  in-range reserve this cycle (bypass pend)
//             rd_addr            read index
//             rd_data, rd_pend   read result
//             rd_oor             read index is out of range (combinational)
//  Revision : 1.0  initial release
// ============================================================================
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int NREGS    = RF_NREGS,
    parameter int AW       = RF_AW,
    parameter int READ_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] regs [NREGS],
    input  logic [NREGS-1:0] pend,
    input  logic             wr_fwd,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rsv_fwd,
    input  logic [AW-1:0]    rsv_addr,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_pend,
    output logic             rd_oor
);

    logic [WIDTH-1:0] w_mux_data;
    logic             w_mux_pend;
    logic             w_hit_wr;
    logic [WIDTH-1:0] w_data;
    logic             w_pend;

    // Extra leading zero keeps the compare correct when NREGS == 2**AW.
    assign rd_oor = !({1'b0, rd_addr} < (AW+1)'(NREGS));

    // Out-of-range indices match no entry, so they read data 0 / pend 0.
    always_comb begin
        w_mux_data = '0;
        w_mux_pend = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (rd_addr == AW'(i)) begin
                w_mux_data = regs[i];
                w_mux_pend = pend[i];
            end
        end
    end

    generate
        if (BYPASS != 0) begin : g_bypass
            // wr_fwd is already range-qualified, so a hit implies a valid index.
            assign w_hit_wr = wr_fwd && (wr_addr == rd_addr);

            always_comb begin
                w_data = w_mux_data;
                w_pend = w_mux_pend;
                if (w_hit_wr) begin
                    // The write clears pending unless a new producer is
                    // reserving the same register on the same edge.
                    w_data = wr_data;
                    w_pend = rsv_fwd && (rsv_addr == rd_addr);
                end
            end
        end else begin : g_no_bypass
            logic w_unused_fwd;
            assign w_unused_fwd = ^{wr_fwd, wr_addr, wr_data, rsv_fwd, rsv_addr};
            assign w_hit_wr     = 1'b0;
            assign w_data       = w_mux_data;
            assign w_pend       = w_mux_pend;
        end
    endgenerate

    generate
        if (READ_REG != 0) begin : g_out_reg
            logic [WIDTH-1:0] r_data;
            logic             r_pend;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_data <= '0;
                    r_pend <= 1'b0;
                end else begin
                    r_data <= w_data;
                    r_pend <= w_pend;
                end
            end

            assign rd_data = r_data;
            assign rd_pend = r_pend;
        end else begin : g_out_comb
            logic w_unused_clk;
            assign w_unused_clk = clk ^ reset;
            assign rd_data      = w_data;
            assign rd_pend      = w_pend;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/regfile_2r1w_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_2r1w_sb
//  Purpose  : Parametrised 2-read / 1-write register file with a per-register
//             pending (scoreboard) bit set by issue and cleared by writeback.
//  Ports    : clk, reset                  clock / async active-high reset
//             wr_en, wr_addr, wr_data     writeback port
//             rsv_en, rsv_addr            reserve (issue) port
//             rd_addr_a/b                 read indices
//             rd_data_a/b, rd_pend_a/b    read data and pending flags
//             any_pending                 OR of all pending bits
//             addr_err                    out-of-range index seen last cycle
//  Revision : 1.0  initial release
// ============================================================================
module regfile_2r1w_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int NREGS    = RF_NREGS,
    parameter int AW       = RF_AW,
    parameter int READ_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    output logic             rd_pend_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             rd_pend_b,
    output logic             any_pending,
    output logic             addr_err
);

    logic [WIDTH-1:0] r_regs [NREGS];
    logic [NREGS-1:0] r_pend;
    logic             r_addr_err;

    logic w_wr_in_range;
    logic w_rsv_in_range;
    logic w_wr_ok;
    logic w_rsv_ok;
    logic w_oor_a;
    logic w_oor_b;
    logic w_err_next;

    assign w_wr_in_range  = {1'b0, wr_addr}  < (AW+1)'(NREGS);
    assign w_rsv_in_range = {1'b0, rsv_addr} < (AW+1)'(NREGS);
    assign w_wr_ok        = wr_en  && w_wr_in_range;
    assign w_rsv_ok       = rsv_en && w_rsv_in_range;

    // Read indices have no enable, so they are always range-checked.
    assign w_err_next = (wr_en  && !w_wr_in_range)
                     || (rsv_en && !w_rsv_in_range)
                     || w_oor_a || w_oor_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_wr_ok && (wr_addr == AW'(i))) begin
                    r_regs[i] <= wr_data;
                end
            end
        end
    end

    // Reserve is applied after the write-clear so that a same-edge
    // write+reserve leaves the bit set for the newly issued producer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_wr_ok && (wr_addr == AW'(i))) begin
                    r_pend[i] <= 1'b0;
                end
                if (w_rsv_ok && (rsv_addr == AW'(i))) begin
                    r_pend[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= w_err_next;
        end
    end

    assign any_pending = |r_pend;
    assign addr_err    = r_addr_err;

    // Nothing is written while reset is high, so nothing may be forwarded.
    logic w_wr_fwd;
    logic w_rsv_fwd;
    assign w_wr_fwd  = w_wr_ok  && !reset;
    assign w_rsv_fwd = w_rsv_ok && !reset;

    regfile_read_port #(
        .WIDTH    (WIDTH),
        .NREGS    (NREGS),
        .AW       (AW),
        .READ_REG (READ_REG),
        .BYPASS   (BYPASS)
    ) u_port_a (
        .clk      (clk),
        .reset    (reset),
        .regs     (r_regs),
        .pend     (r_pend),
        .wr_fwd   (w_wr_fwd),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_fwd  (w_rsv_fwd),
        .rsv_addr (rsv_addr),
        .rd_addr  (rd_addr_a),
        .rd_data  (rd_data_a),
        .rd_pend  (rd_pend_a),
        .rd_oor   (w_oor_a)
    );

    regfile_read_port #(
        .WIDTH    (WIDTH),
        .NREGS    (NREGS),
        .AW       (AW),
        .READ_REG (READ_REG),
        .BYPASS   (BYPASS)
    ) u_port_b (
        .clk      (clk),
        .reset    (reset),
        .regs     (r_regs),
        .pend     (r_pend),
        .wr_fwd   (w_wr_fwd),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_fwd  (w_rsv_fwd),
        .rsv_addr (rsv_addr),
        .rd_addr  (rd_addr_b),
        .rd_data  (rd_data_b),
        .rd_pend  (rd_pend_b),
        .rd_oor   (w_oor_b)
    );

endmodule
`default_nettype wire

// File: tb/tb_regfile_2r1w_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_2r1w_sb
//  Purpose  : Self-checking bench for regfile_2r1w_sb. Three configurations
//             share one stimulus stream:
//               k=0  NREGS=8, combinational read, bypass
//               k=1  NREGS=6, registered read,    no bypass
//               k=2  NREGS=8, combinational read, no bypass
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_2r1w_sb;

    localparam int NK = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        rsv_en = 1'b0;
    logic [2:0]  rsv_addr = '0;
    logic [2:0]  rd_addr_a = '0;
    logic [2:0]  rd_addr_b = '0;

    logic [15:0] o_da [NK];
    logic [15:0] o_db [NK];
    logic        o_pa [NK];
    logic        o_pb [NK];
    logic        o_any [NK];
    logic        o_err [NK];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_2r1w_sb #(.WIDTH(16), .NREGS(8), .AW(3), .READ_REG(0), .BYPASS(1)) dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rd_addr_a(rd_addr_a), .rd_data_a(o_da[0]), .rd_pend_a(o_pa[0]),
        .rd_addr_b(rd_addr_b), .rd_data_b(o_db[0]), .rd_pend_b(o_pb[0]),
        .any_pending(o_any[0]), .addr_err(o_err[0]));

    regfile_2r1w_sb #(.WIDTH(16), .NREGS(6), .AW(3), .READ_REG(1), .BYPASS(0)) dut1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rd_addr_a(rd_addr_a), .rd_data_a(o_da[1]), .rd_pend_a(o_pa[1]),
        .rd_addr_b(rd_addr_b), .rd_data_b(o_db[1]), .rd_pend_b(o_pb[1]),
        .any_pending(o_any[1]), .addr_err(o_err[1]));

    regfile_2r1w_sb #(.WIDTH(16), .NREGS(8), .AW(3), .READ_REG(0), .BYPASS(0)) dut2 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rd_addr_a(rd_addr_a), .rd_data_a(o_da[2]), .rd_pend_a(o_pa[2]),
        .rd_addr_b(rd_addr_b), .rd_data_b(o_db[2]), .rd_pend_b(o_pb[2]),
        .any_pending(o_any[2]), .addr_err(o_err[2]));

    function automatic int nr_of(input int k);
        return (k == 1) ? 6 : 8;
    endfunction
    function automatic bit rr_of(input int k);
        return (k == 1);
    endfunction
    function automatic bit bp_of(input int k);
        return (k == 0);
    endfunction

    // ---------------- reference model ----------------
    logic [15:0] m_mem  [NK][8];
    logic        m_pend [NK][8];
    logic        m_err  [NK];
    logic [15:0] m_qa [NK];
    logic [15:0] m_qb [NK];
    logic        m_qpa [NK];
    logic        m_qpb [NK];

    // What a read of index a returns right now, given current inputs.
    function automatic void exp_read(input int k, input logic [2:0] a,
                                     output logic [15:0] d, output logic p);
        if (int'(a) >= nr_of(k)) begin
            d = '0;
            p = 1'b0;
        end else if (bp_of(k) && wr_en && !reset && wr_addr == a) begin
            d = wr_data;
            p = rsv_en && (rsv_addr == a);
        end else begin
            d = m_mem[k][a];
            p = m_pend[k][a];
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NK; k++) begin
            for (int i = 0; i < 8; i++) begin
                m_mem[k][i]  = '0;
                m_pend[k][i] = 1'b0;
            end
            m_err[k] = 1'b0;
            m_qa[k] = '0; m_qb[k] = '0; m_qpa[k] = 1'b0; m_qpb[k] = 1'b0;
        end
    endfunction

    // Effect of the coming rising edge with the current inputs.
    function automatic void model_step();
        logic [15:0] d;
        logic        p;
        int          n;
        if (reset) begin
            model_reset();
            return;
        end
        for (int k = 0; k < NK; k++) begin
            n = nr_of(k);
            if (rr_of(k)) begin
                exp_read(k, rd_addr_a, d, p); m_qa[k] = d; m_qpa[k] = p;
                exp_read(k, rd_addr_b, d, p); m_qb[k] = d; m_qpb[k] = p;
            end
            m_err[k] = (wr_en && int'(wr_addr) >= n) || (rsv_en && int'(rsv_addr) >= n)
                    || int'(rd_addr_a) >= n || int'(rd_addr_b) >= n;
            if (wr_en && int'(wr_addr) < n) begin
                m_mem[k][wr_addr]  = wr_data;
                m_pend[k][wr_addr] = 1'b0;
            end
            if (rsv_en && int'(rsv_addr) < n) begin
                m_pend[k][rsv_addr] = 1'b1;
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [15:0] ea, eb;
        logic        pa, pb, anyp;
        for (int k = 0; k < NK; k++) begin
            if (rr_of(k)) begin
                ea = m_qa[k]; eb = m_qb[k]; pa = m_qpa[k]; pb = m_qpb[k];
            end else begin
                exp_read(k, rd_addr_a, ea, pa);
                exp_read(k, rd_addr_b, eb, pb);
            end
            anyp = 1'b0;
            for (int i = 0; i < nr_of(k); i++) anyp = anyp | m_pend[k][i];
            check($sformatf("k%0d rd_data_a", k), 32'(o_da[k]), 32'(ea));
            check($sformatf("k%0d rd_data_b", k), 32'(o_db[k]), 32'(eb));
            check($sformatf("k%0d rd_pend_a", k), 32'(o_pa[k]), 32'(pa));
            check($sformatf("k%0d rd_pend_b", k), 32'(o_pb[k]), 32'(pb));
            check($sformatf("k%0d any_pending", k), 32'(o_any[k]), 32'(anyp));
            check($sformatf("k%0d addr_err", k), 32'(o_err[k]), 32'(m_err[k]));
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < NK; k++) begin
            check($sformatf("%s k%0d data_a", tag, k), 32'(o_da[k]), 32'h0);
            check($sformatf("%s k%0d data_b", tag, k), 32'(o_db[k]), 32'h0);
            check($sformatf("%s k%0d pend_a", tag, k), 32'(o_pa[k]), 32'h0);
            check($sformatf("%s k%0d pend_b", tag, k), 32'(o_pb[k]), 32'h0);
            check($sformatf("%s k%0d any", tag, k), 32'(o_any[k]), 32'h0);
            check($sformatf("%s k%0d err", tag, k), 32'(o_err[k]), 32'h0);
        end
    endtask

    // Inputs are driven at posedge+1; outputs are checked at the negedge.
    task automatic to_neg();
        @(negedge clk);
        check_model();
    endtask
    task automatic finish_cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask
    task automatic tick();
        to_neg();
        finish_cycle();
    endtask

    task automatic drive(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                         input logic re, input logic [2:0] ra,
                         input logic [2:0] aa, input logic [2:0] ab);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rsv_en = re; rsv_addr = ra; rd_addr_a = aa; rd_addr_b = ab;
    endtask

    // ---------------- table vectors (k=0 exact, plus k=2 port A) ----------------
    typedef struct {
        logic        we;  logic [2:0] wa; logic [15:0] wd;
        logic        re;  logic [2:0] ra;
        logic [2:0]  aa;  logic [2:0] ab;
        logic [15:0] ea;  logic [15:0] eb;
        logic        epa; logic epb; logic eany;
        logic [15:0] ea2;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                                input logic re, input logic [2:0] ra,
                                input logic [2:0] aa, input logic [2:0] ab,
                                input logic [15:0] ea, input logic [15:0] eb,
                                input logic epa, input logic epb, input logic eany,
                                input logic [15:0] ea2);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra; v.aa = aa; v.ab = ab;
        v.ea = ea; v.eb = eb; v.epa = epa; v.epb = epb; v.eany = eany; v.ea2 = ea2;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [10];

        tbl[0] = mk(1, 3, 16'h1234, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000);
        tbl[1] = mk(1, 5, 16'hABCD, 0, 0, 3, 5, 16'h1234, 16'hABCD, 0, 0, 0, 16'h1234);
        tbl[2] = mk(0, 0, 16'h0000, 0, 0, 3, 5, 16'h1234, 16'hABCD, 0, 0, 0, 16'h1234);
        tbl[3] = mk(1, 2, 16'h00F0, 0, 0, 2, 3, 16'h00F0, 16'h1234, 0, 0, 0, 16'h0000);
        tbl[4] = mk(0, 0, 16'h0000, 1, 6, 6, 2, 16'h0000, 16'h00F0, 0, 0, 0, 16'h0000);
        tbl[5] = mk(0, 0, 16'h0000, 0, 0, 6, 6, 16'h0000, 16'h0000, 1, 1, 1, 16'h0000);
        tbl[6] = mk(1, 6, 16'h0042, 0, 0, 6, 6, 16'h0042, 16'h0042, 0, 0, 1, 16'h0000);
        tbl[7] = mk(0, 0, 16'h0000, 0, 0, 6, 2, 16'h0042, 16'h00F0, 0, 0, 0, 16'h0042);
        tbl[8] = mk(1, 6, 16'h0042, 1, 6, 6, 6, 16'h0042, 16'h0042, 1, 1, 0, 16'h0042);
        tbl[9] = mk(0, 0, 16'h0000, 0, 0, 6, 2, 16'h0042, 16'h00F0, 1, 0, 1, 16'h0042);

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("por");
        reset = 1'b0;

        // Fill every register with FFFF, then reset asynchronously.
        for (int i = 0; i < 8; i++) begin
            drive(1, 3'(i), 16'hFFFF, 0, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 3, 5);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all_zero("rst_after_fill");
        tick();
        reset = 1'b0;
        to_neg();
        check("post_release k0 data_a", 32'(o_da[0]), 32'h0);
        check("post_release k0 data_b", 32'(o_db[0]), 32'h0);
        finish_cycle();

        // Table vectors.
        for (int r = 0; r < 10; r++) begin
            drive(tbl[r].we, tbl[r].wa, tbl[r].wd, tbl[r].re, tbl[r].ra, tbl[r].aa, tbl[r].ab);
            to_neg();
            check($sformatf("vec%0d k0 data_a", r), 32'(o_da[0]), 32'(tbl[r].ea));
            check($sformatf("vec%0d k0 data_b", r), 32'(o_db[0]), 32'(tbl[r].eb));
            check($sformatf("vec%0d k0 pend_a", r), 32'(o_pa[0]), 32'(tbl[r].epa));
            check($sformatf("vec%0d k0 pend_b", r), 32'(o_pb[0]), 32'(tbl[r].epb));
            check($sformatf("vec%0d k0 any", r), 32'(o_any[0]), 32'(tbl[r].eany));
            check($sformatf("vec%0d k2 data_a", r), 32'(o_da[2]), 32'(tbl[r].ea2));
            finish_cycle();
        end

        // Out-of-range write and read on the NREGS=6 instance.
        drive(1, 7, 16'hDEAD, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 7, 0);
        to_neg();
        check("oor_write k1 addr_err", 32'(o_err[1]), 32'h1);
        finish_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        to_neg();
        check("oor_read k1 data_a", 32'(o_da[1]), 32'h0);
        check("oor_read k1 addr_err", 32'(o_err[1]), 32'h1);
        finish_cycle();
        to_neg();
        check("oor_clear k1 addr_err", 32'(o_err[1]), 32'h0);
        check("inrange k0 addr_err", 32'(o_err[0]), 32'h0);
        finish_cycle();

        // Registered-read latency on k=1.
        drive(1, 1, 16'h1111, 0, 0, 1, 0);
        tick();
        drive(1, 4, 16'h4444, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        to_neg();
        check("rreg k1 R1", 32'(o_da[1]), 32'h1111);
        finish_cycle();
        drive(0, 0, 0, 0, 0, 4, 0);
        to_neg();
        check("rreg k1 before edge N", 32'(o_da[1]), 32'h1111);
        finish_cycle();
        to_neg();
        check("rreg k1 after edge N", 32'(o_da[1]), 32'h4444);
        finish_cycle();

        // Reset mid-burst: outputs drop at once, a coincident write is lost.
        drive(1, 2, 16'h2222, 1, 3, 4, 2);
        tick();
        drive(1, 5, 16'hBEEF, 1, 5, 4, 5);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all_zero("rst_midburst");
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 5, 4);
        to_neg();
        check("lost_write k0 R5", 32'(o_da[0]), 32'h0);
        check("lost_write k0 R4", 32'(o_db[0]), 32'h0);
        finish_cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                  1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
